// File: rtl/dev_bus_pkg.sv
// Shared types and constants for the timer-bridge bus arbiter.
// Holds FSM encoding, device window defaults, latched request layout and the decode helper.
package dev_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] DEV_BASE_DEF = 32'h0000_7F00;
  localparam logic [31:0] DEV_MASK_DEF = 32'hFFFF_FFE0;

  // Timer bridge register blocks inside the window
  localparam logic [31:0] TC1_BASE = 32'h0000_7F00;
  localparam logic [31:0] TC2_BASE = 32'h0000_7F10;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return ((addr & mask) == base) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: lone requester wins, a tie goes to the one not granted last.
// Combinational, zero latency; no backpressure of its own.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       valid_o
);

  always_comb begin
    grant_o = 1'b0;
    valid_o = |req_i;
    case (req_i)
      2'b01:   grant_o = 1'b0;
      2'b10:   grant_o = 1'b1;
      2'b11:   grant_o = ~last_grant_i;
      default: grant_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Two-master arbiter onto the timer bridge; each access runs IDLE->BUSY->DONE (ack two cycles after the IDLE edge).
// Masters hold req until ack; one transaction per three cycles, no other backpressure.
module dev_bus_arbiter
  import dev_bus_pkg::*;
#(
  parameter logic [31:0] DEV_BASE   = DEV_BASE_DEF,
  parameter logic [31:0] DEV_MASK   = DEV_MASK_DEF,
  parameter logic        RESET_LAST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,

  output logic [31:0] dev_addr,
  output logic        dev_we,
  output logic [31:0] dev_wdata,
  input  logic [31:0] dev_rdata
);

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        hit_q, hit_d;
  req_t        txn_q, txn_d;
  logic [31:0] rdata_q, rdata_d;

  logic [1:0]  req_vec;
  logic        win_idx;
  logic        win_vld;
  req_t        win_req;

  assign req_vec = {m1_req, m0_req};

  rr_arb2 u_rr_arb2 (
    .req_i        (req_vec),
    .last_grant_i (last_q),
    .grant_o      (win_idx),
    .valid_o      (win_vld)
  );

  always_comb begin
    win_req = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
    if (win_idx) begin
      win_req = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    hit_d   = hit_q;
    txn_d   = txn_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_BUSY;
          gnt_d   = win_idx;
          last_d  = win_idx;
          txn_d   = win_req;
          hit_d   = addr_hit(win_req.addr, DEV_BASE, DEV_MASK);
        end
      end
      ST_BUSY: begin
        // Captured for writes too; a miss returns zero rather than bus garbage
        rdata_d = hit_q ? dev_rdata : 32'h0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= RESET_LAST;
      hit_q   <= 1'b0;
      txn_q   <= '0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      hit_q   <= hit_d;
      txn_q   <= txn_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    dev_addr  = 32'h0;
    dev_wdata = 32'h0;
    dev_we    = 1'b0;
    m0_ack    = 1'b0;
    m0_err    = 1'b0;
    m0_rdata  = 32'h0;
    m1_ack    = 1'b0;
    m1_err    = 1'b0;
    m1_rdata  = 32'h0;
    if (state_q == ST_BUSY) begin
      dev_addr  = txn_q.addr;
      dev_wdata = txn_q.wdata;
      dev_we    = txn_q.we & hit_q;
    end
    if (state_q == ST_DONE) begin
      if (gnt_q) begin
        m1_ack   = 1'b1;
        m1_err   = ~hit_q;
        m1_rdata = rdata_q;
      end else begin
        m0_ack   = 1'b1;
        m0_err   = ~hit_q;
        m0_rdata = rdata_q;
      end
    end
  end

endmodule
